pc_branch_ctrl: RTL and testbench

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

---
 rtl/pc_branch_ctrl.sv | 115 +++++++++++
 tb/tb_pc_branch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_ctrl.sv
// Program-counter sequencer with a 32-entry, 8-bit branch-target table.
// On reset, INIT rebuilds the table so that entry i holds i. The controller then waits in IDLE.
// In RUN, the PC steps by one, takes a branch, stalls, or halts.
// Optional feature: define PC_BRANCH_REL_EN to enable PC-relative branches (BranchRel).
// Without it, every branch is absolute.
module pc_branch_ctrl #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned TBL_DEPTH = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            BranchEn,
  input  logic [4:0]      BranchIdx,
  input  logic            BranchRel,
  input  logic            TblWe,
  input  logic [4:0]      TblAddr,
  input  logic [7:0]      TblData,
  output logic [PC_W-1:0] PC,
  output logic            Busy,
  output logic            Done
);

  localparam logic [4:0] LastIdx = 5'(TBL_DEPTH - 1);

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StRun,
    StHalted
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [4:0]      init_cnt_q, init_cnt_d;
  logic [7:0]      tbl_q [TBL_DEPTH];
  logic [7:0]      tgt_raw;
  logic [PC_W-1:0] br_tgt;

  // The lookup reads the registered table, so a same-cycle write is not visible to the branch.
  assign tgt_raw = tbl_q[BranchIdx];

`ifdef PC_BRANCH_REL_EN
  // The relative offset is sign-extended; the sum wraps modulo 2^PC_W.
  assign br_tgt = BranchRel ? pc_q + PC_W'($signed(tgt_raw)) : PC_W'(tgt_raw);
`else
  logic unused_rel;
  assign unused_rel = BranchRel;
  assign br_tgt     = PC_W'(tgt_raw);
`endif

  // Next-state, next-PC and init-counter logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + 5'd1;
        if (init_cnt_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      StIdle, StHalted: begin
        if (Start) begin
          pc_d    = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (Halt) begin
          state_d = StHalted;
        end else if (Stall) begin
          pc_d = pc_q;
        end else if (BranchEn) begin
          pc_d = br_tgt;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = StInit;
    endcase
  end

  // State, PC and init counter, with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= StInit;
      pc_q       <= '0;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Target table: filled by INIT and written by the user outside INIT; reset does not clear it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (state_q == StInit) begin
        tbl_q[init_cnt_q] <= 8'(init_cnt_q);
      end else if (TblWe) begin
        tbl_q[TblAddr] <= TblData;
      end
    end
  end

  assign PC   = pc_q;
  assign Busy = (state_q == StInit) || (state_q == StRun);
  assign Done = (state_q == StHalted);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed bench for pc_branch_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pc_branch_ctrl;

  localparam int unsigned PC_W = 10;

  logic            Clk = 1'b0;
  logic            Reset, Start, Stall, Halt, BranchEn, BranchRel, TblWe;
  logic [4:0]      BranchIdx, TblAddr;
  logic [7:0]      TblData;
  logic [PC_W-1:0] PC;
  logic            Busy, Done;

  int total = 0;
  int bad   = 0;

  pc_branch_ctrl #(.PC_W(PC_W), .TBL_DEPTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchEn(BranchEn), .BranchIdx(BranchIdx), .BranchRel(BranchRel),
    .TblWe(TblWe), .TblAddr(TblAddr), .TblData(TblData),
    .PC(PC), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(negedge Clk);
  endtask

  // Counts Busy samples from the current one until Busy drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Busy) break;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    Reset = 1'b0;
    tick();
    total++; if (PC !== 10'd0 || Busy !== 1'b1 || Done !== 1'b0) begin
      bad++; $display("FAIL reset_state: PC=%0d Busy=%b Done=%b want 0 1 0", PC, Busy, Done);
    end
    Reset = 1'b1;
    // Writes attempted during INIT must be dropped.
    TblWe = 1'b1; TblAddr = 5'd3; TblData = 8'd99;
    count_busy(n);
    TblWe = 1'b0;
    total++; if (n != 32) begin
      bad++; $display("FAIL init_len: busy_cycles=%0d want 32", n);
    end
    total++; if (PC !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL idle_state: PC=%0d Busy=%b Done=%b want 0 0 0", PC, Busy, Done);
    end
  endtask

  task automatic test_abs_branch();
    TblWe = 1'b1; TblAddr = 5'd5; TblData = 8'd72;
    tick();
    TblWe = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    total++; if (PC !== 10'd0 || Busy !== 1'b1) begin
      bad++; $display("FAIL start: PC=%0d Busy=%b want 0 1", PC, Busy);
    end
    tick();
    Start = 1'b1;  // ignored in RUN
    tick();
    Start = 1'b0;
    total++; if (PC !== 10'd2) begin
      bad++; $display("FAIL start_in_run: PC=%0d want 2", PC);
    end
    tick();
    total++; if (PC !== 10'd3) begin
      bad++; $display("FAIL count: PC=%0d want 3", PC);
    end
    BranchEn = 1'b1; BranchIdx = 5'd5; BranchRel = 1'b0;
    tick();
    total++; if (PC !== 10'd72) begin
      bad++; $display("FAIL abs_branch: PC=%0d want 72", PC);
    end
    BranchIdx = 5'd3;
    tick();
    BranchEn = 1'b0;
    total++; if (PC !== 10'd3) begin
      bad++; $display("FAIL init_write_ignored: PC=%0d want 3", PC);
    end
  endtask

  task automatic test_rel_branch();
    logic [PC_W-1:0] exp_pc;
`ifdef PC_BRANCH_REL_EN
    exp_pc = 10'd8;
`else
    exp_pc = 10'd254;
`endif
    BranchEn = 1'b1; BranchIdx = 5'd10; BranchRel = 1'b0;
    TblWe = 1'b1; TblAddr = 5'd6; TblData = 8'hFE;
    tick();
    TblWe = 1'b0;
    total++; if (PC !== 10'd10) begin
      bad++; $display("FAIL branch_to_10: PC=%0d want 10", PC);
    end
    BranchIdx = 5'd6; BranchRel = 1'b1;
    tick();
    BranchEn = 1'b0; BranchRel = 1'b0;
    total++; if (PC !== exp_pc) begin
      bad++; $display("FAIL rel_branch: PC=%0d want %0d", PC, exp_pc);
    end
  endtask

  task automatic test_priority();
    BranchEn = 1'b1; BranchIdx = 5'd4;
    tick();
    total++; if (PC !== 10'd4) begin
      bad++; $display("FAIL branch_to_4: PC=%0d want 4", PC);
    end
    Stall = 1'b1; BranchIdx = 5'd9;
    tick();
    total++; if (PC !== 10'd4 || Busy !== 1'b1) begin
      bad++; $display("FAIL stall_over_branch: PC=%0d Busy=%b want 4 1", PC, Busy);
    end
    Halt = 1'b1;
    tick();
    Halt = 1'b0; Stall = 1'b0;
    total++; if (PC !== 10'd4 || Done !== 1'b1 || Busy !== 1'b0) begin
      bad++; $display("FAIL halt: PC=%0d Done=%b Busy=%b want 4 1 0", PC, Done, Busy);
    end
    tick();  // branch still requested, must be ignored in HALTED
    BranchEn = 1'b0;
    total++; if (PC !== 10'd4 || Done !== 1'b1) begin
      bad++; $display("FAIL halted_hold: PC=%0d Done=%b want 4 1", PC, Done);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    total++; if (PC !== 10'd0 || Done !== 1'b0 || Busy !== 1'b1) begin
      bad++; $display("FAIL restart: PC=%0d Done=%b Busy=%b want 0 0 1", PC, Done, Busy);
    end
  endtask

  task automatic test_wrap_collision();
    bit hit = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (PC === 10'd1023) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    total++; if (!hit) begin
      bad++; $display("FAIL reach_1023: PC=%0d want 1023", PC);
    end
    tick();
    total++; if (PC !== 10'd0) begin
      bad++; $display("FAIL wrap: PC=%0d want 0", PC);
    end
    TblWe = 1'b1; TblAddr = 5'd7; TblData = 8'd9;
    BranchEn = 1'b1; BranchIdx = 5'd7;
    tick();
    TblWe = 1'b0;
    total++; if (PC !== 10'd7) begin
      bad++; $display("FAIL same_cycle_old: PC=%0d want 7", PC);
    end
    tick();
    BranchEn = 1'b0;
    total++; if (PC !== 10'd9) begin
      bad++; $display("FAIL write_visible: PC=%0d want 9", PC);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    TblWe = 1'b1; TblAddr = 5'd21; TblData = 8'd50;
    tick();
    TblWe = 1'b0; BranchEn = 1'b1; BranchIdx = 5'd21;
    tick();
    BranchEn = 1'b0;
    total++; if (PC !== 10'd50) begin
      bad++; $display("FAIL branch_to_50: PC=%0d want 50", PC);
    end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    total++; if (PC !== 10'd0 || Busy !== 1'b1 || Done !== 1'b0) begin
      bad++; $display("FAIL run_reset: PC=%0d Busy=%b Done=%b want 0 1 0", PC, Busy, Done);
    end
    count_busy(n);
    total++; if (n != 32) begin
      bad++; $display("FAIL reinit_len: busy_cycles=%0d want 32", n);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0; BranchEn = 1'b1; BranchIdx = 5'd5;
    tick();
    total++; if (PC !== 10'd5) begin
      bad++; $display("FAIL rebuilt_5: PC=%0d want 5", PC);
    end
    BranchIdx = 5'd7;
    tick();
    BranchEn = 1'b0;
    total++; if (PC !== 10'd7) begin
      bad++; $display("FAIL rebuilt_7: PC=%0d want 7", PC);
    end
  endtask

  task automatic test_reset_mid_init();
    int n;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    repeat (10) tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    count_busy(n);
    total++; if (n != 32) begin
      bad++; $display("FAIL init_restart_len: busy_cycles=%0d want 32", n);
    end
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0; Halt = 1'b0;
    BranchEn = 1'b0; BranchIdx = '0; BranchRel = 1'b0;
    TblWe = 1'b0; TblAddr = '0; TblData = '0;
    test_reset();
    test_abs_branch();
    test_rel_branch();
    test_priority();
    test_wrap_collision();
    test_reset_mid_run();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
